// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-bit encodings, default datapath width and
// the buffered result entry.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [5:0] CTL_ZX = 6'd32;
  localparam logic [5:0] CTL_NX = 6'd16;
  localparam logic [5:0] CTL_ZY = 6'd8;
  localparam logic [5:0] CTL_NY = 6'd4;
  localparam logic [5:0] CTL_F  = 6'd2;
  localparam logic [5:0] CTL_NO = 6'd1;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 z;
    logic                 lt;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU producer, the result stage and the
// writeback consumer.
interface alu_result_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 2
) ();

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_out;
  logic             flags_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_z;
  logic             out_lt;
  logic             flag_z;
  logic             flag_lt;
  logic [LW-1:0]    level;

  modport master (
    output in_valid, alu_out, flags_en, out_ready,
    input  in_ready, out_valid, out_data, out_z, out_lt, flag_z, flag_lt, level
  );

  modport slave (
    input  in_valid, alu_out, flags_en, out_ready,
    output in_ready, out_valid, out_data, out_z, out_lt, flag_z, flag_lt, level
  );

endinterface

// File: rtl/alu_flag_calc.sv
// Zero / sign-negative decode of an ALU result.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             z,
  output logic             lt
);

  assign z  = (data == '0);
  assign lt = data[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result FIFO with per-entry flags and the architectural
// Z/LT flags register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             z;
    logic             lt;
  } slot_t;

  slot_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic           flag_z_q;
  logic           flag_lt_q;

  logic           push_c;
  logic           pop_c;
  logic           in_z_c;
  logic           in_lt_c;

  alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .data (bus.alu_out),
    .z    (in_z_c),
    .lt   (in_lt_c)
  );

  // Ready/valid decode only from registered occupancy: no full pass-through, no empty bypass.
  assign push_c = bus.in_valid && (level_q < LW'(DEPTH));
  assign pop_c  = bus.out_ready && (level_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      flag_z_q  <= 1'b0;
      flag_lt_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push_c && bus.flags_en) begin
        flag_z_q  <= in_z_c;
        flag_lt_q <= in_lt_c;
      end
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{data: bus.alu_out, z: in_z_c, lt: in_lt_c};
    end
  end

  assign bus.in_ready  = (level_q < LW'(DEPTH));
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_z     = mem[rd_ptr].z;
  assign bus.out_lt    = mem[rd_ptr].lt;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_lt   = flag_lt_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + randomized bench for alu_result_stage with DEPTH=2 and DEPTH=4
// instances, each shadowed by a scoreboard/occupancy model.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv   [2];
  logic [15:0] din  [2];
  logic        fe   [2];
  logic        ordy [2];

  logic        rdy [2];
  logic        ov  [2];
  logic [15:0] od  [2];
  logic        oz  [2];
  logic        olt [2];
  logic        fz  [2];
  logic        flt [2];
  logic [3:0]  lv  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : 4;

    alu_result_stage_if #(.WIDTH(16), .DEPTH(D)) bus ();

    alu_result_stage #(.WIDTH(16), .DEPTH(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid  = iv[g];
    assign bus.alu_out   = din[g];
    assign bus.flags_en  = fe[g];
    assign bus.out_ready = ordy[g];
    assign rdy[g] = bus.in_ready;
    assign ov[g]  = bus.out_valid;
    assign od[g]  = bus.out_data;
    assign oz[g]  = bus.out_z;
    assign olt[g] = bus.out_lt;
    assign fz[g]  = bus.flag_z;
    assign flt[g] = bus.flag_lt;
    assign lv[g]  = 4'(bus.level);

    alu_entry_t  exp_q [$];
    int unsigned mlvl = 0;
    logic        mz = 1'b0;
    logic        mlt = 1'b0;

    // Mid-cycle monitor: occupancy/flags model and in-order result scoreboard.
    always @(negedge clk) begin
      alu_entry_t e;
      logic push, pop;
      if (!rst_n) begin
        exp_q.delete();
        mlvl = 0;
        mz   = 1'b0;
        mlt  = 1'b0;
      end else begin
        check($sformatf("d%0d level", D), 32'(lv[g]), mlvl);
        check($sformatf("d%0d in_ready", D), 32'(rdy[g]), 32'(mlvl < D));
        check($sformatf("d%0d out_valid", D), 32'(ov[g]), 32'(mlvl != 0));
        check($sformatf("d%0d flag_z", D), 32'(fz[g]), 32'(mz));
        check($sformatf("d%0d flag_lt", D), 32'(flt[g]), 32'(mlt));
        push = iv[g] && (mlvl < D);
        pop  = ordy[g] && (mlvl != 0);
        if (pop) begin
          if (exp_q.size() == 0) begin
            check($sformatf("d%0d scoreboard underflow", D), 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("d%0d out_data", D), 32'(od[g]), 32'(e.data));
            check($sformatf("d%0d out_z", D), 32'(oz[g]), 32'(e.z));
            check($sformatf("d%0d out_lt", D), 32'(olt[g]), 32'(e.lt));
          end
        end
        if (push) begin
          e.data = din[g];
          e.z    = (din[g] == 16'h0000);
          e.lt   = din[g][15];
          exp_q.push_back(e);
          if (fe[g]) begin
            mz  = e.z;
            mlt = e.lt;
          end
        end
        mlvl = mlvl + 32'(push) - 32'(pop);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    logic acc [2];
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b0; din[g] = '0; fe[g] = 1'b0; ordy[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset in_ready", 32'(rdy[0]), 1);
    check("reset out_valid", 32'(ov[0]), 0);
    check("reset level", 32'(lv[0]), 0);
    check("reset flag_z", 32'(fz[0]), 0);
    check("reset flag_lt", 32'(flt[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single push of zero with flag update.
    iv[0] = 1'b1; din[0] = 16'h0000; fe[0] = 1'b1;
    tick();
    iv[0] = 1'b0; fe[0] = 1'b0;
    check("single out_valid", 32'(ov[0]), 1);
    check("single out_data", 32'(od[0]), 32'h0000);
    check("single out_z", 32'(oz[0]), 1);
    check("single flag_z", 32'(fz[0]), 1);
    check("single flag_lt", 32'(flt[0]), 0);
    check("single level", 32'(lv[0]), 1);
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    check("single drained", 32'(lv[0]), 0);

    // Fill and stall.
    iv[0] = 1'b1; din[0] = 16'h8001;
    tick();
    din[0] = 16'h0005;
    tick();
    din[0] = 16'h1234;
    check("full level", 32'(lv[0]), 2);
    check("full in_ready", 32'(rdy[0]), 0);
    repeat (3) begin
      tick();
      check("stall in_ready", 32'(rdy[0]), 0);
      check("stall level", 32'(lv[0]), 2);
    end
    check("stall head", 32'(od[0]), 32'h8001);
    check("stall head lt", 32'(olt[0]), 1);
    ordy[0] = 1'b1;
    tick();
    check("drain1 level", 32'(lv[0]), 1);
    check("drain1 head", 32'(od[0]), 32'h0005);
    check("drain1 in_ready", 32'(rdy[0]), 1);
    tick();
    iv[0] = 1'b0;
    check("drain2 head", 32'(od[0]), 32'h1234);
    check("drain2 level", 32'(lv[0]), 1);
    tick();
    check("drain3 level", 32'(lv[0]), 0);

    // Streaming at full throughput.
    for (int x = 0; x <= 900; x += 100) begin
      iv[0] = 1'b1; din[0] = 16'(x + 567);
      tick();
      check("stream data", 32'(od[0]), 32'(x + 567));
      check("stream level", 32'(lv[0]), 1);
      check("stream in_ready", 32'(rdy[0]), 1);
    end
    iv[0] = 1'b0;
    tick();
    check("stream drained", 32'(lv[0]), 0);

    // Flags gating.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; din[0] = 16'hFFFF; fe[0] = 1'b1;
    tick();
    din[0] = 16'h0000; fe[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    check("gate flag_lt", 32'(flt[0]), 1);
    check("gate flag_z", 32'(fz[0]), 0);
    check("gate head", 32'(od[0]), 32'hFFFF);
    ordy[0] = 1'b1;
    tick();
    check("gate second z", 32'(oz[0]), 1);
    check("gate second data", 32'(od[0]), 32'h0000);
    check("gate flag_z hold", 32'(fz[0]), 0);
    tick();
    ordy[0] = 1'b0;
    check("gate drained", 32'(lv[0]), 0);

    // Randomized handshakes on both depths.
    for (int c = 0; c < 1000; c++) begin
      for (int g = 0; g < 2; g++) acc[g] = iv[g] && rdy[g];
      tick();
      for (int g = 0; g < 2; g++) begin
        if (!iv[g] || acc[g]) begin
          iv[g]  = 1'($urandom_range(0, 1));
          din[g] = 16'($urandom);
          fe[g]  = 1'($urandom_range(0, 1));
        end
        ordy[g] = 1'($urandom_range(0, 1));
      end
    end
    for (int g = 0; g < 2; g++) begin
      acc[g] = iv[g] && rdy[g];
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b0; fe[g] = 1'b0; ordy[g] = 1'b1;
    end
    repeat (6) tick();
    check("random d2 drained", 32'(lv[0]), 0);
    check("random d4 drained", 32'(lv[1]), 0);
    ordy[0] = 1'b0; ordy[1] = 1'b0;

    // Asynchronous reset mid-stream.
    iv[0] = 1'b1; din[0] = 16'hFFFF; fe[0] = 1'b1;
    tick();
    din[0] = 16'h0007; fe[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    check("pre-reset level", 32'(lv[0]), 2);
    check("pre-reset flag_lt", 32'(flt[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(ov[0]), 0);
    check("async level", 32'(lv[0]), 0);
    check("async flag_z", 32'(fz[0]), 0);
    check("async flag_lt", 32'(flt[0]), 0);
    check("async in_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    iv[0] = 1'b1; din[0] = 16'h0042; fe[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0; fe[0] = 1'b0;
    check("post-reset out_valid", 32'(ov[0]), 1);
    check("post-reset data", 32'(od[0]), 32'h0042);
    check("post-reset level", 32'(lv[0]), 1);
    check("post-reset flag_z", 32'(fz[0]), 0);
    tick();
    check("post-reset drained", 32'(lv[0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage sitting directly downstream of the 16-bit ALU (X, Y, 6-bit control zx/nx/zy/ny/f/no → 16-bit result). It captures each ALU result under a valid/ready handshake into a small FIFO, computes the zero and negative flags alongside it, and maintains the architectural flags register (Z, LT) consumed by conditional jumps. Its output feeds the bus-writeback logic, which may stall.

## Interface
- `WIDTH`, 16: result width; the flags are derived from this width.
- `DEPTH`, 2: FIFO entries; must be a power of two and at least 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: an ALU result is present on `alu_out`.
- `in_ready`  out  1: the stage can accept a result this cycle.
- `alu_out`  in  WIDTH: combinational ALU result.
- `flags_en`  in  1: when the result is accepted, update the architectural flags from it.
- `out_valid`  out  1: a buffered result is available at the head.
- `out_ready`  in  1: the downstream consumer takes the head this cycle.
- `out_data`  out  WIDTH: head result.
- `out_z`  out  1: head result equals 0.
- `out_lt`  out  1: head result bit WIDTH-1 (signed negative).
- `flag_z`  out  1: architectural zero flag.
- `flag_lt`  out  1: architectural less-than flag.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** occurs when `in_valid && in_ready`. Writes {`alu_out`, z, lt} at the write pointer, with z = (`alu_out` == 0) and lt = `alu_out`[WIDTH-1].
- **Pop:** occurs when `out_valid && out_ready`. Advances the read pointer.
- **Pointers:** `$clog2(DEPTH)` bits each; they wrap modulo DEPTH with no special case.
- **`in_ready`:** equals (`level` < DEPTH) and is a function of registered state only. When full, `in_ready` is 0 even if a pop happens in the same cycle; there is no full-pass-through.
- **`out_valid`:** equals (`level` != 0). There is no empty-bypass: a result pushed into an empty FIFO appears on the next cycle.
- **Simultaneous push and pop:** allowed whenever 0 < `level` < DEPTH; `level` stays unchanged.
- **`level` update:** +1 on push only, −1 on pop only, otherwise unchanged.
- **Architectural flags:**
  - On a push with `flags_en` = 1, `flag_z` and `flag_lt` take that result's z and lt at the same edge, independent of draining.
  - A push with `flags_en` = 0, or a rejected `in_valid`, leaves the flags unchanged.
- **Head outputs when empty:** `out_data`, `out_z` and `out_lt` are don't-care. The bench must not check them while `out_valid` = 0.
- **Producer rules:**
  - Once raised, `in_valid` must hold with a stable `alu_out` until accepted.
  - The stage must not drop or duplicate results under any `out_ready` pattern.

## Timing
- **Reset (async assert, sync-safe deassert):**
  - `level` = 0, pointers = 0, `out_valid` = 0, `in_ready` = 1.
  - `flag_z` = 0, `flag_lt` = 0.
  - FIFO storage is not reset.
- **Latency:** push at edge N → `out_valid` = 1 with that data after edge N, visible in cycle N+1.
- **Flag latency:** the flags change at the push edge.
- **Throughput:** one result per cycle when `out_ready` is held at 1.
- **Reset mid-operation:** the FIFO empties immediately and buffered results are lost; the flags clear. The first push after `rst_n` rises behaves as from an empty FIFO.
- **Combinational paths:** none from inputs to outputs. `out_*`, `in_ready`, `level` and the flags are all registered or decoded from registered state.

## Structure
- **Shared package `alu_pkg`:**
  - ALU control bit constants: ZX=32, NX=16, ZY=8, NY=4, F=2, NO=1.
  - Default WIDTH = 16.
  - A packed entry struct {data, z, lt}.
- **Sub-module `alu_flag_calc`:** combinational, WIDTH in → z, lt out. It is instantiated once on the push path and reused by upstream checkers.
- **Storage:** a plain register array. No RAM macro.

## Test plan
- **Reset and single push:** reset, then push 0x0000 with `flags_en` = 1 → next cycle `out_valid` = 1, `out_data` = 0x0000, `out_z` = 1, `flag_z` = 1, `flag_lt` = 0, `level` = 1.
- **Fill and stall:** `out_ready` = 0, push 0x8001 then 0x0005 → `level` = 2, `in_ready` = 0. A third `in_valid` with 0x1234 held for 3 cycles is not accepted. Raise `out_ready` → outputs 0x8001 (`out_lt` = 1), then 0x0005, then 0x1234 is accepted and drained in order.
- **Streaming:** `out_ready` = 1, push X+Y results for x = 0..900 step 100 with y = 567 → every result appears one cycle later, in order. `level` stays at 1 throughout, and `in_ready` never drops.
- **Flags gating:** push 0xFFFF with `flags_en` = 1, then 0x0000 with `flags_en` = 0 → `flag_lt` = 1 and `flag_z` = 0 persist. The FIFO head still shows `out_z` = 1 for the second entry.
- **Wrap-around:** random `in_valid`/`out_ready` (50%) for 1000 cycles with the `DEPTH` = 2 and `DEPTH` = 4 builds → scoreboard shows no loss or duplication, and `level` always equals pushes minus pops.
- **Reset mid-stream:** assert `rst_n` = 0 with `level` = 2 → `out_valid` = 0, `level` = 0 and flags = 0 immediately, without waiting for a clock edge. After release, push 0x0042 → it is output next.
